// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/D memory port arbiter.
package mem_port_arbiter_pkg;
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY_IF = 2'd1,
      ST_BUSY_D  = 2'd2
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } gnt_t;

   localparam int TIMEOUT_DEF = 16;
endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// Saturating access-age counter; expires when an access has waited TIMEOUT-1 cycles.
module mem_port_arbiter_watchdog
   import mem_port_arbiter_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int CW = $clog2(TIMEOUT) + 1;

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni)
         cnt_q <= '0;
      else if (clr_i)
         cnt_q <= '0;
      else if (en_i && (cnt_q != '1))
         cnt_q <= cnt_q + 1'b1;
   end

   assign expired_o = (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one MIO port between instruction fetch and data access,
// with a watchdog that aborts accesses the bus never acknowledges.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          if_req_i,
   input  logic [AW-1:0] if_addr_i,
   output logic          if_done_o,
   output logic [DW-1:0] if_rdata_o,
   input  logic          d_req_i,
   input  logic          d_we_i,
   input  logic [AW-1:0] d_addr_i,
   input  logic [DW-1:0] d_wdata_i,
   output logic          d_done_o,
   output logic [DW-1:0] d_rdata_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   input  logic [DW-1:0] mem_rdata_i,
   input  logic          mem_ready_i,
   output logic          stall_o,
   output logic          bus_err_o
);
   state_t        state_q;
   gnt_t          last_q;
   logic          if_done_q, d_done_q, mem_req_q, mem_we_q, bus_err_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
   logic          busy, gnt_any, gnt_d, wd_exp;

   assign busy = (state_q != ST_IDLE);
   // Hold off arbitration while a done pulse is out: the finishing requester's
   // req is still the stale one and must not be granted again.
   assign gnt_any = !busy && !if_done_q && !d_done_q && (if_req_i || d_req_i);
   assign gnt_d   = d_req_i && (!if_req_i || (last_q == GNT_IF));

   mem_port_arbiter_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clr_i     (gnt_any),
      .en_i      (busy && !mem_ready_i),
      .expired_o (wd_exp)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         last_q      <= GNT_IF;
         if_done_q   <= 1'b0;
         d_done_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
         bus_err_q   <= 1'b0;
      end else begin
         if_done_q <= 1'b0;
         d_done_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (gnt_any) begin
                  mem_req_q <= 1'b1;
                  if (gnt_d) begin
                     state_q     <= ST_BUSY_D;
                     last_q      <= GNT_D;
                     mem_we_q    <= d_we_i;
                     mem_addr_q  <= d_addr_i;
                     mem_wdata_q <= d_wdata_i;
                  end else begin
                     state_q     <= ST_BUSY_IF;
                     last_q      <= GNT_IF;
                     mem_we_q    <= 1'b0;
                     mem_addr_q  <= if_addr_i;
                     mem_wdata_q <= '0;
                  end
               end
            end
            default: begin
               if (mem_ready_i || wd_exp) begin
                  state_q   <= ST_IDLE;
                  mem_req_q <= 1'b0;
                  if (!mem_ready_i)
                     bus_err_q <= 1'b1;
                  if (state_q == ST_BUSY_D) begin
                     d_done_q  <= 1'b1;
                     d_rdata_q <= mem_ready_i ? mem_rdata_i : '0;
                  end else begin
                     if_done_q  <= 1'b1;
                     if_rdata_q <= mem_ready_i ? mem_rdata_i : '0;
                  end
               end
            end
         endcase
      end
   end

   assign if_done_o   = if_done_q;
   assign d_done_o    = d_done_q;
   assign if_rdata_o  = if_rdata_q;
   assign d_rdata_o   = d_rdata_q;
   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign bus_err_o   = bus_err_q;
   assign stall_o     = (if_req_i && !if_done_q) || (d_req_i && !d_done_q);
endmodule
